// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - integer ALU with iterative radix-2 multiply/divide path
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int M_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] a_q, a_d;
  logic            neg_q, neg_d;
  logic            negr_q, negr_d;
  logic            bzero_q, bzero_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;

  op_e dec_op;
  always_comb begin
    dec_op = OP_ADD;
    if (alu_op == 2'b01) begin
      dec_op = OP_SUB;
    end else if (alu_op[1]) begin
      if (alu_op == 2'b10 && funct7_0) begin
        // Without the M path this encoding falls back to ADD
        if (M_EN != 0) begin
          case (funct3)
            3'b000:  dec_op = OP_MUL;
            3'b001:  dec_op = OP_MULH;
            3'b010:  dec_op = OP_MULHSU;
            3'b011:  dec_op = OP_MULHU;
            3'b100:  dec_op = OP_DIV;
            3'b101:  dec_op = OP_DIVU;
            3'b110:  dec_op = OP_REM;
            default: dec_op = OP_REMU;
          endcase
        end
      end else begin
        case (funct3)
          3'b000: begin
            if (alu_op == 2'b10 && funct7_5) dec_op = OP_SUB;
            else                             dec_op = OP_ADD;
          end
          3'b001: dec_op = OP_SLL;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b101: begin
            if (funct7_5) dec_op = OP_SRA;
            else          dec_op = OP_SRL;
          end
          3'b110: dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    end
  end

  logic            lt_c, ltu_c, dec_is_m, a_sgn, b_sgn, a_neg, b_neg;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, a_mag, b_mag;

  assign shamt    = src_b[SHW-1:0];
  assign lt_c     = $signed(src_a) < $signed(src_b);
  assign ltu_c    = src_a < src_b;
  assign dec_is_m = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                   OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign a_sgn    = dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn    = dec_op inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg    = a_sgn & src_a[XLEN-1];
  assign b_neg    = b_sgn & src_b[XLEN-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign b_mag    = b_neg ? -src_b : src_b;

  always_comb begin
    alu_res = src_a + src_b;
    case (dec_op)
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_c};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, ltu_c};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      default: ;
    endcase
  end

  // acc/lo hold product hi/lo while multiplying, remainder/quotient while dividing
  logic              q_is_div, div_ge, accept;
  logic [XLEN:0]     mul_sum, div_sh;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  assign q_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {acc_q, lo_q[XLEN-1]};
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign prod     = {acc_q, lo_q};
  assign prod_s   = neg_q ? -prod : prod;
  assign quo_s    = neg_q ? -lo_q : lo_q;
  assign rem_s    = negr_q ? -acc_q : acc_q;

  always_comb begin
    fix_res = prod_s[XLEN-1:0];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = bzero_q ? '1 : quo_s;
      OP_REM, OP_REMU:              fix_res = bzero_q ? a_q : rem_s;
      default: ;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign result    = res_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    a_d     = a_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    bzero_d = bzero_q;
    res_d   = res_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE && out_ready) state_d = S_IDLE;
          if (accept) begin
            op_d  = dec_op;
            lt_d  = lt_c;
            ltu_d = ltu_c;
            if (dec_is_m) begin
              state_d = S_CALC;
              cnt_d   = '0;
              acc_d   = '0;
              lo_d    = a_mag;
              opb_d   = b_mag;
              a_d     = src_a;
              neg_d   = a_neg ^ b_neg;
              negr_d  = a_neg;
              bzero_d = (src_b == '0);
            end else begin
              state_d = S_DONE;
              res_d   = alu_res;
              zero_d  = (alu_res == '0);
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + CW'(1);
          if (q_is_div) begin
            acc_d = div_ge ? (div_sh[XLEN-1:0] - opb_q) : div_sh[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], div_ge};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_LAST) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          res_d   = fix_res;
          zero_d  = (fix_res == '0);
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      bzero_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      bzero_q <= bzero_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, funct7_5, funct7_0, flush;
  logic            out_valid, out_ready, zero, lt, ltu, busy;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a, src_b, result;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .M_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .src_a(src_a), .src_b(src_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .lt(lt), .ltu(ltu),
    .busy(busy)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        lt;
    logic        ltu;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                                 input logic f70, input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic [63:0]        p;
    logic [31:0]        r;
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = a + b;
    if (op == 2'b01) begin
      r = a - b;
    end else if (op == 2'b10 && f70) begin
      case (f3)
        3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
        3'd4: begin
          if (b == 0) r = 32'hFFFF_FFFF;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
          else r = $signed(a) / $signed(b);
        end
        3'd5: begin
          if (b == 0) r = 32'hFFFF_FFFF;
          else r = a / b;
        end
        3'd6: begin
          if (b == 0) r = a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
          else r = $signed(a) % $signed(b);
        end
        default: begin
          if (b == 0) r = a;
          else r = a % b;
        end
      endcase
    end else if (op[1]) begin
      case (f3)
        3'd0: begin
          if (op == 2'b10 && f75) r = a - b;
          else r = a + b;
        end
        3'd1: r = a << b[4:0];
        3'd2: r = {31'b0, $signed(a) < $signed(b)};
        3'd3: r = {31'b0, a < b};
        3'd4: r = a ^ b;
        3'd5: begin
          if (f75) r = $unsigned($signed(a) >>> b[4:0]);
          else r = a >> b[4:0];
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    e.res  = r;
    e.zero = (r == 0);
    e.lt   = $signed(a) < $signed(b);
    e.ltu  = a < b;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("out_without_request", out_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", result, e.res);
        check_eq("zero", zero, e.zero);
        check_eq("lt", lt, e.lt);
        check_eq("ltu", ltu, e.ltu);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                      input logic [31:0] a, input logic [31:0] b, input bit exp_out,
                      output int acc_cyc);
    int   n;
    logic acc;
    n = 0;
    alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; src_a = a; src_b = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready && !flush;
      n++;
      @(posedge clk);
      #1;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    acc_cyc = cyc;
    check_eq("accept_timeout", acc, 1'b1);
    if (exp_out) sb_q.push_back(model(op, f3, f75, f70, a, b));
  endtask

  task automatic wait_valid(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end while (!out_valid && lat < 100);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   lat, nb, c, ca, cb, n, nv;
    exp_t hold_e;
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0;
    funct7_0 = 1'b0; src_a = '0; src_b = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_flags", {zero, lt, ltu}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    send(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, ca);
    wait_valid(lat, nb);
    check_eq("sub_latency", lat, 1);
    send(2'b11, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, ca);
    wait_valid(lat, nb);
    check_eq("addi_latency", lat, 1);

    send(2'b10, 3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, ca);
    wait_valid(lat, nb);
    check_eq("mulh_latency", lat, 34);
    check_eq("mulh_busy_cycles", nb, 33);
    send(2'b10, 3'b100, 1'b0, 1'b1, 32'd7, 32'd0, 1'b1, ca);
    wait_valid(lat, nb);
    check_eq("div0_latency", lat, 34);
    send(2'b10, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, ca);
    send(2'b10, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, ca);
    send(2'b10, 3'b111, 1'b0, 1'b1, 32'd1234, 32'd0, 1'b1, ca);
    send(2'b10, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, ca);

    // result must hold while the consumer stalls, then the next op enters with no bubble
    wait_valid(lat, nb);
    out_ready = 1'b0;
    send(2'b10, 3'b111, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, ca);
    hold_e = model(2'b10, 3'b111, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_result", result, hold_e.res);
      check_eq("hold_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    c = cyc;
    send(2'b11, 3'b100, 1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, ca);
    check_eq("accept_in_done", ca, c + 1);
    send(2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0010, 32'd4, 1'b1, cb);
    check_eq("back_to_back", cb, ca + 1);

    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'b1, ca);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("scoreboard_drained", sb_q.size(), 0);

    send(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, ca);
    wait_valid(lat, nb);

    send(2'b10, 3'b101, 1'b0, 1'b1, 32'd1000, 32'd3, 1'b0, ca);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("busy_before_flush", busy, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_in_ready", in_ready, 1'b1);
    check_eq("flush_busy", busy, 1'b0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check_eq("flush_no_output", nv, 0);

    @(posedge clk);
    #1;
    send(2'b10, 3'b000, 1'b0, 1'b1, 32'd99, 32'd77, 1'b0, ca);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_result", result, 32'h0);
    check_eq("midrst_flags", {zero, lt, ltu}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_in_ready", in_ready, 1'b1);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check_eq("midrst_no_output", nv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
